// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, single-cycle ALU and EX/MEM register.
// Define EX_STAGE_MULDIV_EN to add the iterative XLEN-step mul/div unit (codes 11-14).
module ex_stage_md #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_ex,
  input  logic            flush_ex,
  input  logic [3:0]      ALUCode_ex,
  input  logic            ALUSrcA_ex,
  input  logic [1:0]      ALUSrcB_ex,
  input  logic [XLEN-1:0] Imm_ex,
  input  logic [XLEN-1:0] PC_ex,
  input  logic [XLEN-1:0] rs1Data_ex,
  input  logic [XLEN-1:0] rs2Data_ex,
  input  logic [4:0]      rs1Addr_ex,
  input  logic [4:0]      rs2Addr_ex,
  input  logic [4:0]      rdAddr_ex,
  input  logic            RegWrite_ex,
  input  logic [XLEN-1:0] ALUResult_mem,
  input  logic [XLEN-1:0] RegWriteData_wb,
  input  logic [4:0]      rdAddr_mem,
  input  logic [4:0]      rdAddr_wb,
  input  logic            RegWrite_mem,
  input  logic            RegWrite_wb,
  output logic            stall_ex,
  output logic [XLEN-1:0] ALUResult_exmem,
  output logic [XLEN-1:0] MemWriteData_exmem,
  output logic [4:0]      rdAddr_exmem,
  output logic            RegWrite_exmem,
  output logic            valid_exmem
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB   = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_SLL   = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,  OP_SLTU  = 4'd9,  OP_PASSB = 4'd10, OP_MUL = 4'd11,
    OP_MULHU = 4'd12, OP_DIVU = 4'd13, OP_REMU = 4'd14, OP_ZERO = 4'd15
  } alu_op_e;

  logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_result;
  logic [SHW-1:0]  shamt;

  // Multi-cycle unit handshake into the EX/MEM register.
  logic            md_done;
  logic [XLEN-1:0] md_result, md_wdata;
  logic [4:0]      md_rd;
  logic            md_we;

  // MEM is the younger producer, so it takes priority over WB.
  always_comb begin
    fwd_a = rs1Data_ex;
    if (RegWrite_mem && rdAddr_mem != 5'd0 && rdAddr_mem == rs1Addr_ex)
      fwd_a = ALUResult_mem;
    else if (RegWrite_wb && rdAddr_wb != 5'd0 && rdAddr_wb == rs1Addr_ex)
      fwd_a = RegWriteData_wb;
  end

  always_comb begin
    fwd_b = rs2Data_ex;
    if (RegWrite_mem && rdAddr_mem != 5'd0 && rdAddr_mem == rs2Addr_ex)
      fwd_b = ALUResult_mem;
    else if (RegWrite_wb && rdAddr_wb != 5'd0 && rdAddr_wb == rs2Addr_ex)
      fwd_b = RegWriteData_wb;
  end

  assign op_a  = ALUSrcA_ex ? PC_ex : fwd_a;
  assign shamt = op_b[SHW-1:0];

  always_comb begin
    case (ALUSrcB_ex)
      2'b00:   op_b = fwd_b;
      2'b01:   op_b = Imm_ex;
      2'b10:   op_b = XLEN'(4);
      default: op_b = '0;
    endcase
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    alu_result = '0;
    case (ALUCode_ex)
      OP_ADD:   alu_result = op_a + op_b;
      OP_SUB:   alu_result = op_a - op_b;
      OP_AND:   alu_result = op_a & op_b;
      OP_OR:    alu_result = op_a | op_b;
      OP_XOR:   alu_result = op_a ^ op_b;
      OP_SLL:   alu_result = op_a << shamt;
      OP_SRL:   alu_result = op_a >> shamt;
      OP_SRA:   alu_result = $signed(op_a) >>> shamt;
      OP_SLT:   alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU:  alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_PASSB: alu_result = op_b;
      default:  alu_result = '0;
    endcase
  end

`ifdef EX_STAGE_MULDIV_EN
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

  md_state_e       state, state_nxt;
  logic [SHW-1:0]  cnt;
  logic [3:0]      md_code;
  logic [XLEN-1:0] md_hi, md_lo, md_b;
  logic            is_md, md_accept, md_last, is_div, div_ge;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;

  assign is_md     = ALUCode_ex inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
  assign md_accept = (state == MD_IDLE) && valid_ex && is_md && !flush_ex;
  assign md_last   = (cnt == SHW'(XLEN-1));
  assign is_div    = (md_code == OP_DIVU) || (md_code == OP_REMU);
  assign md_done   = (state == MD_DONE);

  always_comb begin
    state_nxt = state;
    stall_ex  = 1'b0;
    case (state)
      MD_IDLE: if (md_accept) begin
        state_nxt = MD_BUSY;
        stall_ex  = 1'b1;
      end
      MD_BUSY: begin
        stall_ex = 1'b1;
        if (md_last) state_nxt = MD_DONE;
      end
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
    if (flush_ex) state_nxt = MD_IDLE;
  end

  // hi:lo is {accumulator, multiplier} for mul and {remainder, quotient} for div.
  always_comb begin
    mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : '0);
    div_shift = {md_hi, md_lo[XLEN-1]};
    div_ge    = div_shift >= {1'b0, md_b};
    div_diff  = div_shift - {1'b0, md_b};
  end

  always_comb begin
    case (md_code)
      OP_MULHU, OP_REMU: md_result = md_hi;
      default:           md_result = md_lo;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (md_accept) cnt <= '0;
      else if (state == MD_BUSY) cnt <= cnt + 1'b1;
    end
  end

  // NOTE: operand registers carry no reset; they are always loaded at accept before use.
  always_ff @(posedge clk) begin
    if (md_accept) begin
      md_code  <= ALUCode_ex;
      md_hi    <= '0;
      md_lo    <= op_a;
      md_b     <= op_b;
      md_wdata <= fwd_b;
      md_rd    <= rdAddr_ex;
      md_we    <= RegWrite_ex;
    end else if (state == MD_BUSY) begin
      if (is_div) begin
        md_hi <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        md_lo <= {md_lo[XLEN-2:0], div_ge};
      end else begin
        {md_hi, md_lo} <= {mul_sum, md_lo[XLEN-1:1]};
      end
    end
  end
`else
  assign stall_ex  = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = '0;
  assign md_wdata  = '0;
  assign md_rd     = '0;
  assign md_we     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResult_exmem    <= '0;
      MemWriteData_exmem <= '0;
      rdAddr_exmem       <= '0;
      RegWrite_exmem     <= 1'b0;
      valid_exmem        <= 1'b0;
    end else if (flush_ex || (stall_ex && !md_done)) begin
      RegWrite_exmem <= 1'b0;
      valid_exmem    <= 1'b0;
    end else if (md_done) begin
      ALUResult_exmem    <= md_result;
      MemWriteData_exmem <= md_wdata;
      rdAddr_exmem       <= md_rd;
      RegWrite_exmem     <= md_we;
      valid_exmem        <= 1'b1;
    end else begin
      ALUResult_exmem    <= alu_result;
      MemWriteData_exmem <= fwd_b;
      rdAddr_exmem       <= rdAddr_ex;
      RegWrite_exmem     <= RegWrite_ex & valid_ex;
      valid_exmem        <= valid_ex;
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed + randomized bench for ex_stage_md against a behavioural model;
// exercises the mul/div unit only when EX_STAGE_MULDIV_EN is defined for the build.
module tb_ex_stage_md;

`ifdef EX_STAGE_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, valid_ex, flush_ex, ALUSrcA_ex, RegWrite_ex;
  logic [3:0]  ALUCode_ex;
  logic [1:0]  ALUSrcB_ex;
  logic [31:0] Imm_ex, PC_ex, rs1Data_ex, rs2Data_ex, ALUResult_mem, RegWriteData_wb;
  logic [4:0]  rs1Addr_ex, rs2Addr_ex, rdAddr_ex, rdAddr_mem, rdAddr_wb;
  logic        RegWrite_mem, RegWrite_wb;
  logic        stall_ex, RegWrite_exmem, valid_exmem;
  logic [31:0] ALUResult_exmem, MemWriteData_exmem;
  logic [4:0]  rdAddr_exmem;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage_md #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .valid_ex(valid_ex), .flush_ex(flush_ex),
    .ALUCode_ex(ALUCode_ex), .ALUSrcA_ex(ALUSrcA_ex), .ALUSrcB_ex(ALUSrcB_ex),
    .Imm_ex(Imm_ex), .PC_ex(PC_ex), .rs1Data_ex(rs1Data_ex), .rs2Data_ex(rs2Data_ex),
    .rs1Addr_ex(rs1Addr_ex), .rs2Addr_ex(rs2Addr_ex), .rdAddr_ex(rdAddr_ex),
    .RegWrite_ex(RegWrite_ex), .ALUResult_mem(ALUResult_mem),
    .RegWriteData_wb(RegWriteData_wb), .rdAddr_mem(rdAddr_mem), .rdAddr_wb(rdAddr_wb),
    .RegWrite_mem(RegWrite_mem), .RegWrite_wb(RegWrite_wb), .stall_ex(stall_ex),
    .ALUResult_exmem(ALUResult_exmem), .MemWriteData_exmem(MemWriteData_exmem),
    .rdAddr_exmem(rdAddr_exmem), .RegWrite_exmem(RegWrite_exmem), .valid_exmem(valid_exmem)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- behavioural reference model ----
  function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (RegWrite_mem && rdAddr_mem != 0 && rdAddr_mem == rs) return ALUResult_mem;
    if (RegWrite_wb && rdAddr_wb != 0 && rdAddr_wb == rs) return RegWriteData_wb;
    return rf;
  endfunction

  function automatic logic [31:0] m_alu(input int code, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint unsigned prod = ua * ub;
    int sh = int'(b % 32);
    int sa = int'(a);
    int sb = int'(b);
    if (!MD && code >= 11 && code <= 14) return 32'd0;
    case (code)
      0:  return 32'(ua + ub);
      1:  return 32'(ua - ub);
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return 32'(ua * (64'd1 << sh));
      6:  return 32'(ua / (64'd1 << sh));
      7:  return 32'(sa >>> sh);
      8:  return (sa < sb) ? 32'd1 : 32'd0;
      9:  return (ua < ub) ? 32'd1 : 32'd0;
      10: return b;
      11: return prod[31:0];
      12: return prod[63:32];
      13: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      14: return (b == 0) ? a : 32'(ua % ub);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_opa();
    return ALUSrcA_ex ? PC_ex : m_fwd(rs1Addr_ex, rs1Data_ex);
  endfunction

  function automatic logic [31:0] m_opb();
    case (ALUSrcB_ex)
      2'b00:   return m_fwd(rs2Addr_ex, rs2Data_ex);
      2'b01:   return Imm_ex;
      2'b10:   return 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  task automatic no_fwd();
    RegWrite_mem = 0; RegWrite_wb = 0; rdAddr_mem = 0; rdAddr_wb = 0;
    ALUResult_mem = 0; RegWriteData_wb = 0;
  endtask

  task automatic drive(input logic [3:0] code, input logic sa, input logic [1:0] sb,
                       input logic [31:0] r1d, input logic [31:0] r2d, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd);
    valid_ex = 1; flush_ex = 0; RegWrite_ex = 1; ALUCode_ex = code;
    ALUSrcA_ex = sa; ALUSrcB_ex = sb; rs1Data_ex = r1d; rs2Data_ex = r2d;
    Imm_ex = imm; PC_ex = pc; rs1Addr_ex = r1; rs2Addr_ex = r2; rdAddr_ex = rd;
  endtask

  // One single-cycle instruction: expectation from the model, then one edge.
  task automatic run_single(input string tag);
    logic [31:0] exp_res, exp_wd;
    logic        exp_valid, exp_we;
    logic [4:0]  exp_rd;
    exp_res   = m_alu(int'(ALUCode_ex), m_opa(), m_opb());
    exp_wd    = m_fwd(rs2Addr_ex, rs2Data_ex);
    exp_valid = valid_ex && !flush_ex;
    exp_we    = exp_valid && RegWrite_ex;
    exp_rd    = rdAddr_ex;
    check({tag, "_stall"}, stall_ex, 0);
    tick();
    check({tag, "_valid"}, valid_exmem, exp_valid);
    check({tag, "_we"}, RegWrite_exmem, exp_we);
    if (exp_valid) begin
      check({tag, "_result"}, ALUResult_exmem, exp_res);
      check({tag, "_wdata"}, MemWriteData_exmem, exp_wd);
      check({tag, "_rd"}, rdAddr_exmem, exp_rd);
    end
  endtask

`ifdef EX_STAGE_MULDIV_EN
  // One mul/div instruction held by upstream until stall drops; forwarding
  // sources are scrambled while busy to show operands were captured at accept.
  task automatic run_md(input string tag);
    logic [31:0] exp_res, exp_wd;
    logic [4:0]  exp_rd;
    int          cycles;
    bit          bubble_ok;
    exp_res   = m_alu(int'(ALUCode_ex), m_opa(), m_opb());
    exp_wd    = m_fwd(rs2Addr_ex, rs2Data_ex);
    exp_rd    = rdAddr_ex;
    cycles    = 0;
    bubble_ok = 1;
    while (stall_ex === 1'b1 && cycles < 200) begin
      cycles++;
      tick();
      if (valid_exmem !== 1'b0 || RegWrite_exmem !== 1'b0) bubble_ok = 0;
      ALUResult_mem = $urandom; RegWriteData_wb = $urandom;
    end
    check({tag, "_stall_cycles"}, cycles, 33);
    check({tag, "_bubble"}, bubble_ok, 1);
    tick();
    check({tag, "_valid"}, valid_exmem, 1);
    check({tag, "_we"}, RegWrite_exmem, 1);
    check({tag, "_result"}, ALUResult_exmem, exp_res);
    check({tag, "_wdata"}, MemWriteData_exmem, exp_wd);
    check({tag, "_rd"}, rdAddr_exmem, exp_rd);
    valid_ex = 0;
  endtask
`endif

  initial begin
    // Reset wins over a simultaneous flush and accept.
    no_fwd();
    drive(4'd0, 0, 2'b01, 32'h5, 32'h6, 32'h7, 32'h0, 5'd1, 5'd2, 5'd3);
    flush_ex = 1;
    reset = 1;
    tick(); tick();
    check("rst_stall", stall_ex, 0);
    check("rst_valid", valid_exmem, 0);
    check("rst_we", RegWrite_exmem, 0);
    check("rst_result", ALUResult_exmem, 0);
    check("rst_wdata", MemWriteData_exmem, 0);
    check("rst_rd", rdAddr_exmem, 0);
    reset = 0;
    flush_ex = 0;

    // MEM beats WB on the same register.
    no_fwd();
    RegWrite_mem = 1; rdAddr_mem = 5'd5; ALUResult_mem = 32'h10;
    RegWrite_wb  = 1; rdAddr_wb  = 5'd5; RegWriteData_wb = 32'h20;
    drive(4'd0, 0, 2'b00, 32'hDEAD_BEEF, 32'h3, 32'h0, 32'h0, 5'd5, 5'd6, 5'd7);
    run_single("fwd_mem_over_wb");
    check("fwd_mem_over_wb_lit", ALUResult_exmem, 32'h13);

    // x0 never forwards even if MEM claims to write it.
    no_fwd();
    RegWrite_mem = 1; rdAddr_mem = 5'd0; ALUResult_mem = 32'h55;
    drive(4'd0, 0, 2'b01, 32'h0, 32'h0, 32'h7, 32'h0, 5'd0, 5'd0, 5'd8);
    run_single("x0_nofwd");
    check("x0_nofwd_lit", ALUResult_exmem, 32'h7);

    // Store data is the forwarded rs2 even when B selects the immediate.
    no_fwd();
    RegWrite_wb = 1; rdAddr_wb = 5'd9; RegWriteData_wb = 32'hCAFE;
    drive(4'd0, 0, 2'b01, 32'h10, 32'h1111, 32'h100, 32'h0, 5'd4, 5'd9, 5'd10);
    run_single("store_fwd");
    check("store_fwd_lit", MemWriteData_exmem, 32'hCAFE);

    no_fwd();
    drive(4'd0, 1, 2'b10, 32'h0, 32'h0, 32'h0, 32'h1000, 5'd1, 5'd2, 5'd1);
    run_single("pc_plus4");
    check("pc_plus4_lit", ALUResult_exmem, 32'h1004);

    drive(4'd3, 0, 2'b11, 32'h1234, 32'hFFFF, 32'hFFFF, 32'h0, 5'd1, 5'd2, 5'd3);
    run_single("or_zero_b");

    drive(4'd7, 0, 2'b01, 32'h8000_0000, 32'h0, 32'h3F, 32'h0, 5'd1, 5'd2, 5'd3);
    run_single("sra_31");
    check("sra_31_lit", ALUResult_exmem, 32'hFFFF_FFFF);

    drive(4'd5, 0, 2'b01, 32'h1, 32'h0, 32'h21, 32'h0, 5'd1, 5'd2, 5'd3);
    run_single("sll_mask");
    check("sll_mask_lit", ALUResult_exmem, 32'h2);

    drive(4'd8, 0, 2'b01, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0, 5'd1, 5'd2, 5'd3);
    run_single("slt_neg");
    drive(4'd9, 0, 2'b01, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0, 5'd1, 5'd2, 5'd3);
    run_single("sltu_big");

    drive(4'd0, 0, 2'b00, 32'h1, 32'h2, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3);
    valid_ex = 0;
    run_single("bubble_invalid");
    drive(4'd0, 0, 2'b00, 32'h1, 32'h2, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3);
    flush_ex = 1;
    run_single("bubble_flush");

`ifndef EX_STAGE_MULDIV_EN
    // Without the unit, mul/div codes are single-cycle zero and never stall.
    for (int c = 11; c <= 14; c++) begin
      drive(4'(c), 0, 2'b00, 32'h64, 32'h7, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3);
      run_single($sformatf("md_off_%0d", c));
      check($sformatf("md_off_%0d_lit", c), ALUResult_exmem, 32'h0);
    end
`else
    no_fwd();
    drive(4'd11, 0, 2'b00, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3);
    run_md("mul");
    check("mul_lit", ALUResult_exmem, 32'hFFFF_FFFE);
    drive(4'd12, 0, 2'b00, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3);
    run_md("mulhu");
    check("mulhu_lit", ALUResult_exmem, 32'h1);
    drive(4'd13, 0, 2'b00, 32'd100, 32'd0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3);
    run_md("divu_0");
    check("divu_0_lit", ALUResult_exmem, 32'hFFFF_FFFF);
    drive(4'd14, 0, 2'b00, 32'd100, 32'd0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3);
    run_md("remu_0");
    check("remu_0_lit", ALUResult_exmem, 32'd100);
    drive(4'd13, 0, 2'b00, 32'd100, 32'd7, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3);
    run_md("divu_7");
    check("divu_7_lit", ALUResult_exmem, 32'd14);
    drive(4'd14, 0, 2'b00, 32'd100, 32'd7, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3);
    run_md("remu_7");
    check("remu_7_lit", ALUResult_exmem, 32'd2);

    // Forwarded operands captured at accept.
    RegWrite_mem = 1; rdAddr_mem = 5'd1; ALUResult_mem = $urandom;
    drive(4'd11, 0, 2'b00, 32'h0, $urandom, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3);
    run_md("mul_fwd");
    for (int i = 0; i < 4; i++) begin
      no_fwd();
      drive(4'($urandom_range(11, 14)), 0, 2'b00, $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom,
            32'h0, 32'h0, 5'd1, 5'd2, 5'd3);
      run_md($sformatf("md_rand%0d", i));
    end

    // Flush in BUSY cycle 10 aborts; the next ADD goes straight through.
    no_fwd();
    drive(4'd11, 0, 2'b00, 32'h3, 32'h5, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3);
    check("flush_accept_stall", stall_ex, 1);
    for (int i = 0; i < 10; i++) tick();
    flush_ex = 1;
    tick();
    drive(4'd0, 0, 2'b01, 32'h3, 32'h5, 32'h9, 32'h0, 5'd1, 5'd2, 5'd4);
    check("flush_stall_drop", stall_ex, 0);
    check("flush_no_valid", valid_exmem, 0);
    run_single("after_flush_add");

    // Reset mid-BUSY: the aborted multiply never appears.
    drive(4'd11, 0, 2'b00, 32'h3, 32'h5, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3);
    for (int i = 0; i < 6; i++) tick();
    valid_ex = 0;
    reset = 1;
    tick();
    reset = 0;
    check("rst_busy_stall", stall_ex, 0);
    check("rst_busy_valid", valid_exmem, 0);
    begin
      bit quiet = 1;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (valid_exmem !== 1'b0 || stall_ex !== 1'b0) quiet = 0;
      end
      check("rst_busy_quiet", quiet, 1);
    end
`endif

    // Randomized single-cycle traffic with dense forwarding hits.
    for (int i = 0; i < 60; i++) begin
      int c;
      c = MD ? int'($urandom_range(0, 11)) : int'($urandom_range(0, 15));
      if (MD && c == 11) c = 15;
      RegWrite_mem = 1'($urandom); rdAddr_mem = 5'($urandom_range(0, 3));
      RegWrite_wb  = 1'($urandom); rdAddr_wb  = 5'($urandom_range(0, 3));
      ALUResult_mem = $urandom; RegWriteData_wb = $urandom;
      drive(4'(c), 1'($urandom), 2'($urandom), $urandom, $urandom, $urandom, $urandom,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
      RegWrite_ex = 1'($urandom);
      valid_ex    = ($urandom_range(0, 9) != 0);
      flush_ex    = ($urandom_range(0, 9) == 0);
      run_single($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
